// File: rtl/uart_mat_mul_pkg.sv
// Shared types and constants for the UART 2x2 matrix-multiply accelerator.
// Holds the protocol FSM states, the frame byte values and the 8-bit dot-product helper.
package uart_mat_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_JOB,
        ST_DATA,
        ST_CALC,
        ST_TX
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SYNC     = 8'hFF;
    localparam logic [7:0] SEL_A    = 8'h00;
    localparam logic [7:0] SEL_B    = 8'h01;
    localparam int         RESP_LEN = 6;

    // Two-term dot product; the 8-bit result width makes the arithmetic wrap modulo 256.
    function automatic logic [7:0] dot2(input logic [7:0] x0, input logic [7:0] x1,
                                        input logic [7:0] y0, input logic [7:0] y1);
        return x0 * y0 + x1 * y1;
    endfunction

endpackage

// File: rtl/uart_core.sv
// UART 8N1 receiver and transmitter sharing one bit period of CLKS_PER_BIT clocks.
// The transmitter accepts the next byte during the final stop-bit cycle, so bytes go out back to back.
module uart_core
    import uart_mat_mul_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx_busy
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic          rx_meta, rx_s, rx_d;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_tick;

    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF) : (rx_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s && rx_d)            rx_next = RX_START;
            RX_START: if (rx_tick)                  rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_tick)                  rx_next = RX_IDLE;
            default:                                rx_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_d     <= rx_s;
            rx_valid <= 1'b0;
            rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            if (rx_tick) begin
                case (rx_state)
                    RX_START: rx_bit <= '0;
                    RX_DATA: begin
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                    end
                    RX_STOP: if (rx_s) begin
                        rx_byte  <= rx_shift;
                        rx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [9:0]    tx_shift;
    logic          tx_active;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_last;

    assign tx_last = tx_active && tx_bit == 4'd9 && tx_cnt == LAST;
    assign tx_busy = tx_active && !tx_last;
    assign tx      = tx_shift[0];

    // The shifter refills with ones, so its LSB is the idle-high line straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift  <= '1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_start && !tx_busy) begin
            tx_shift  <= {1'b1, tx_byte, 1'b0};
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_active) begin
            if (tx_cnt == LAST) begin
                tx_cnt   <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bit   <= tx_bit + 1'b1;
                if (tx_bit == 4'd9) tx_active <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_mat_mul.sv
// Serial 2x2 matrix multiplier: receives A and B frames over UART, returns C = A*B mod 256.
// Protocol FSM, matrix storage and the multiply-accumulate live here; bit timing is in uart_core.
module uart_mat_mul
    import uart_mat_mul_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT * 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] c11,
    output logic [7:0] c12,
    output logic [7:0] c21,
    output logic [7:0] c22,
    output logic       done,
    output logic       led
);

    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    state_t        state, state_next;
    logic [7:0]    rx_byte, tx_byte;
    logic          rx_valid, tx_start, tx_busy;
    logic          cur_b, a_valid, job_ok, timeout, in_frame;
    logic [7:0]    job_id;
    logic [7:0]    a_m [4];
    logic [7:0]    b_m [4];
    logic [1:0]    idx;
    logic [2:0]    tx_idx;
    logic [TW-1:0] tout_cnt;

    uart_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .tx       (tx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    assign in_frame = state inside {ST_SEL, ST_JOB, ST_DATA};
    assign timeout  = in_frame && !rx_valid && tout_cnt == TW'(TIMEOUT_CLKS - 1);
    assign job_ok   = a_valid && rx_byte == job_id;
    assign tx_start = state == ST_TX && !tx_busy && tx_idx < 3'(RESP_LEN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (rx_valid && rx_byte == SYNC) state_next = ST_SEL;
            ST_SEL: if (rx_valid) begin
                if (rx_byte == SEL_A || rx_byte == SEL_B) state_next = ST_JOB;
                else if (rx_byte != SYNC)                 state_next = ST_IDLE;
            end
            ST_JOB:  if (rx_valid) state_next = (!cur_b || job_ok) ? ST_DATA : ST_IDLE;
            ST_DATA: if (rx_valid && idx == 2'd3) state_next = cur_b ? ST_CALC : ST_IDLE;
            ST_CALC: state_next = ST_TX;
            ST_TX:   if (tx_idx == 3'(RESP_LEN) && !tx_busy) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (timeout) state_next = ST_IDLE;
    end

    always_comb begin
        case (tx_idx)
            3'd0:    tx_byte = SYNC;
            3'd1:    tx_byte = job_id;
            3'd2:    tx_byte = c11;
            3'd3:    tx_byte = c12;
            3'd4:    tx_byte = c21;
            default: tx_byte = c22;
        endcase
    end

    // NOTE: matrix storage has no reset; a_valid and the DATA state guarantee it is written before use.
    always_ff @(posedge clk) begin
        if (state == ST_DATA && rx_valid) begin
            if (cur_b) b_m[idx] <= rx_byte;
            else       a_m[idx] <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_b    <= 1'b0;
            a_valid  <= 1'b0;
            job_id   <= '0;
            idx      <= '0;
            tx_idx   <= '0;
            tout_cnt <= '0;
            c11      <= '0;
            c12      <= '0;
            c21      <= '0;
            c22      <= '0;
            done     <= 1'b0;
            led      <= 1'b0;
        end else begin
            done     <= 1'b0;
            tout_cnt <= (!in_frame || rx_valid) ? '0 : tout_cnt + 1'b1;
            case (state)
                ST_SEL: if (rx_valid) begin
                    if (rx_byte == SEL_A) begin
                        cur_b   <= 1'b0;
                        a_valid <= 1'b0;
                    end else if (rx_byte == SEL_B) begin
                        cur_b <= 1'b1;
                    end
                end
                ST_JOB: if (rx_valid) begin
                    idx <= '0;
                    if (!cur_b) job_id <= rx_byte;
                end
                ST_DATA: if (rx_valid) begin
                    idx <= idx + 1'b1;
                    if (idx == 2'd3 && !cur_b) a_valid <= 1'b1;
                end
                ST_CALC: begin
                    c11    <= dot2(a_m[0], a_m[1], b_m[0], b_m[2]);
                    c12    <= dot2(a_m[0], a_m[1], b_m[1], b_m[3]);
                    c21    <= dot2(a_m[2], a_m[3], b_m[0], b_m[2]);
                    c22    <= dot2(a_m[2], a_m[3], b_m[1], b_m[3]);
                    tx_idx <= '0;
                end
                ST_TX: begin
                    if (tx_start) tx_idx <= tx_idx + 1'b1;
                    if (state_next == ST_IDLE) begin
                        done <= 1'b1;
                        led  <= ~led;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mat_mul.sv
// Self-checking bench for uart_mat_mul: directed and random frames against a matrix-level model.
// A line monitor decodes tx into a byte queue; done pulses are counted independently.
module tb_uart_mat_mul;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       tx, done, led;
    logic [7:0] c11, c12, c21, c22;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [7:0] tx_q [$];

    logic [7:0] m_a [4];
    logic [7:0] m_b [4];
    logic [7:0] m_c [4];
    logic [7:0] m_job;
    bit         m_a_valid;
    logic       m_led;
    int         m_done;

    uart_mat_mul #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .tx   (tx),
        .c11  (c11),
        .c12  (c12),
        .c21  (c21),
        .c22  (c22),
        .done (done),
        .led  (led)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // tx line decoder: samples each bit half a clock into its period
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    v[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                tx_q.push_back(v);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    // Sends a complete frame and applies the frame rules to the model; resp = response expected.
    task automatic frame(input logic [7:0] sel, input logic [7:0] job,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, output bit resp);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        send_byte(8'hFF, 1'b1);
        send_byte(sel, 1'b1);
        send_byte(job, 1'b1);
        for (int i = 0; i < 4; i++) send_byte(e[i], 1'b1);
        resp = 1'b0;
        if (sel == 8'h00) begin
            m_a_valid = 1'b1;
            m_job     = job;
            m_a       = e;
        end else if (sel == 8'h01 && m_a_valid && job == m_job) begin
            m_b = e;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++)
                    m_c[2*r+c] = 8'((int'(m_a[2*r]) * int'(m_b[c]) + int'(m_a[2*r+1]) * int'(m_b[2+c])) % 256);
            resp = 1'b1;
        end
    endtask

    task automatic check_c(input string tag);
        check({tag, "_c11"}, 32'(c11), 32'(m_c[0]));
        check({tag, "_c12"}, 32'(c12), 32'(m_c[1]));
        check({tag, "_c21"}, 32'(c21), 32'(m_c[2]));
        check({tag, "_c22"}, 32'(c22), 32'(m_c[3]));
    endtask

    task automatic check_response(input string tag, input bit resp);
        logic [7:0] exp_bytes [6];
        int n;
        check({tag, "_resp_expected"}, 32'(resp), 32'd1);
        exp_bytes = '{8'hFF, m_job, m_c[0], m_c[1], m_c[2], m_c[3]};
        n = 0;
        while (done_cnt == m_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        m_done++;
        m_led = ~m_led;
        check({tag, "_done_count"}, 32'(done_cnt), 32'(m_done));
        check({tag, "_led"}, 32'(led), 32'(m_led));
        check({tag, "_tx_len"}, 32'(tx_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check($sformatf("%s_tx%0d", tag, i), (tx_q.size() > 0) ? 32'(tx_q.pop_front()) : 32'hDEAD, 32'(exp_bytes[i]));
        tx_q.delete();
        check_c(tag);
    endtask

    task automatic check_silent(input string tag, input bit resp);
        check({tag, "_no_resp_expected"}, 32'(resp), 32'd0);
        repeat (400) @(negedge clk);
        check({tag, "_tx_quiet"}, 32'(tx_q.size()), 32'd0);
        check({tag, "_no_done"}, 32'(done_cnt), 32'(m_done));
        check_c(tag);
    endtask

    initial begin
        bit resp;
        logic [7:0] j;
        m_c = '{8'h00, 8'h00, 8'h00, 8'h00};
        m_a_valid = 1'b0;
        m_job = 8'h00;
        m_led = 1'b0;
        m_done = 0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_led", 32'(led), 32'd0);
        check_c("reset");

        frame(8'h00, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, resp);
        frame(8'h01, 8'h07, 8'h05, 8'h06, 8'h07, 8'h08, resp);
        check("basic_c11_const", 32'(m_c[0]), 32'h13);
        check_response("basic", resp);

        frame(8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, resp);
        frame(8'h01, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, resp);
        check_response("wrap", resp);

        frame(8'h00, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C, resp);
        frame(8'h01, 8'h08, 8'h05, 8'h06, 8'h07, 8'h08, resp);
        check_silent("job_mismatch", resp);

        send_byte(8'hFF, 1'b1);
        send_byte(8'h05, 1'b1);
        frame(8'h00, 8'h22, 8'h11, 8'h22, 8'h33, 8'h44, resp);
        frame(8'h01, 8'h22, 8'h02, 8'h03, 8'h04, 8'h05, resp);
        check_response("bad_sel", resp);

        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h44, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        m_a = '{8'h01, 8'h02, 8'h03, 8'h04};
        m_job = 8'h33;
        m_a_valid = 1'b1;
        frame(8'h01, 8'h33, 8'h10, 8'h20, 8'h30, 8'h40, resp);
        check_response("framing_err", resp);

        for (int k = 0; k < 4; k++) begin
            j = 8'($urandom);
            frame(8'h00, j, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), resp);
            frame(8'h01, j, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), resp);
            check_response($sformatf("rand%0d", k), resp);
        end
        frame(8'h01, j, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), resp);
        check_response("reuse_a", resp);

        send_byte(8'hFF, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h01, 1'b1);
        m_a_valid = 1'b0;
        repeat (16 * CPB * 10 + 100) @(negedge clk);
        frame(8'h01, 8'h07, 8'h05, 8'h06, 8'h07, 8'h08, resp);
        check_silent("timeout", resp);

        frame(8'h00, 8'h5A, 8'h01, 8'h01, 8'h01, 8'h01, resp);
        frame(8'h01, 8'h5A, 8'h02, 8'h02, 8'h02, 8'h02, resp);
        begin
            int n = 0;
            while (tx !== 1'b0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("midtx_tx_low_seen", 32'(tx), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midtx_reset_tx", 32'(tx), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m_a_valid = 1'b0;
        m_job = 8'h00;
        m_led = 1'b0;
        m_c = '{8'h00, 8'h00, 8'h00, 8'h00};
        check("midtx_reset_led", 32'(led), 32'd0);
        check_c("midtx_reset");
        repeat (12 * CPB) @(negedge clk);
        tx_q.delete();
        check("midtx_no_done", 32'(done_cnt), 32'(m_done));

        frame(8'h01, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08, resp);
        check_silent("post_reset_b", resp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
